// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: holds the NZCV flags, counts in-flight flag writers,
// and resolves one conditional branch at a time once the flags are final.
module branch_resolve_unit #(
   parameter int ADDR_W = 32,
   parameter int PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flag_pend_inc,
   input  logic              flag_wr_en,
   input  logic              alu_n,
   input  logic              alu_z,
   input  logic              alu_c,
   input  logic              alu_v,
   input  logic              flush,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [3:0]        br_cond,
   input  logic [ADDR_W-1:0] br_pc,
   input  logic [ADDR_W-1:0] br_offset,
   output logic [3:0]        flags_q,
   output logic              res_valid,
   output logic              res_taken,
   output logic [ADDR_W-1:0] res_target,
   output logic              redirect_valid
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_EVAL
   } state_e;

   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   state_e              state_q;
   logic [PEND_W-1:0]   pend_q, pend_d;
   logic [3:0]          cond_q;
   logic [ADDR_W-1:0]   pc_q, offset_q;
   logic                res_valid_q, res_taken_q;
   logic [ADDR_W-1:0]   res_target_q;
   logic                take;
   logic [ADDR_W-1:0]   target_d;

   function automatic logic cond_take(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         4'd0:    return z;
         4'd1:    return !z;
         4'd2:    return c;
         4'd3:    return !c;
         4'd4:    return n;
         4'd5:    return !n;
         4'd6:    return v;
         4'd7:    return !v;
         4'd8:    return c & !z;
         4'd9:    return !c | z;
         4'd10:   return n == v;
         4'd11:   return n != v;
         4'd12:   return !z & (n == v);
         4'd13:   return z | (n != v);
         4'd14:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // NOTE: every variable driven here gets a default first so no latch is inferred.
   always_comb begin
      pend_d = pend_q;
      if (flag_pend_inc && !flag_wr_en && pend_q != PEND_MAX) begin
         pend_d = pend_q + 1'b1;
      end else if (flag_wr_en && !flag_pend_inc && pend_q != '0) begin
         pend_d = pend_q - 1'b1;
      end
   end

   assign take     = cond_take(cond_q, flags_q);
   assign target_d = take ? (pc_q + offset_q) : (pc_q + ADDR_W'(4));

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         flags_q      <= '0;
         pend_q       <= '0;
         cond_q       <= '0;
         pc_q         <= '0;
         offset_q     <= '0;
         res_valid_q  <= 1'b0;
         res_taken_q  <= 1'b0;
         res_target_q <= '0;
      end else begin
         res_valid_q <= 1'b0;
         pend_q      <= pend_d;
         if (flag_wr_en) begin
            flags_q <= {alu_n, alu_z, alu_c, alu_v};
         end
         // Waiting on pend_d lets the final writeback release the branch on the
         // same edge that lands its flags, so EVAL sees them.
         case (state_q)
            S_IDLE: begin
               if (br_valid && !flush) begin
                  cond_q   <= br_cond;
                  pc_q     <= br_pc;
                  offset_q <= br_offset;
                  state_q  <= (pend_d == '0) ? S_EVAL : S_WAIT;
               end
            end
            S_WAIT: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else if (pend_d == '0) begin
                  state_q <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (!flush) begin
                  res_valid_q  <= 1'b1;
                  res_taken_q  <= take;
                  res_target_q <= target_d;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign br_ready       = (state_q == S_IDLE);
   assign res_valid      = res_valid_q;
   assign res_taken      = res_taken_q;
   assign res_target     = res_target_q;
   assign redirect_valid = res_valid_q & res_taken_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus a
// randomized run compared cycle by cycle against a held-branch reference model.
module tb_branch_resolve_unit;

   localparam int ADDR_W = 32;
   localparam int PMAX   = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flag_pend_inc, flag_wr_en;
   logic              alu_n, alu_z, alu_c, alu_v;
   logic              flush, br_valid, br_ready;
   logic [3:0]        br_cond;
   logic [ADDR_W-1:0] br_pc, br_offset;
   logic [3:0]        flags_q;
   logic              res_valid, res_taken, redirect_valid;
   logic [ADDR_W-1:0] res_target;

   int checks = 0;
   int errors = 0;

   // Reference model: a branch is either absent, waiting, or due for evaluation.
   bit [3:0]        m_flags;
   int              m_pend;
   bit              m_held, m_go, m_rv, m_rt;
   bit [3:0]        m_cond;
   bit [ADDR_W-1:0] m_pc, m_off, m_tgt;

   branch_resolve_unit #(.ADDR_W(ADDR_W), .PEND_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .flag_pend_inc(flag_pend_inc), .flag_wr_en(flag_wr_en),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .flush(flush),
      .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
      .br_offset(br_offset), .flags_q(flags_q), .res_valid(res_valid),
      .res_taken(res_taken), .res_target(res_target), .redirect_valid(redirect_valid)
   );

   always #5 clk = ~clk;

   // Conditions come in complementary pairs: odd codes invert the even predicate.
   function automatic bit ref_take(input bit [3:0] c, input bit [3:0] f);
      bit n, z, cr, v, base;
      {n, z, cr, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cr;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cr && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return c[0] ? !base : base;
   endfunction

   task automatic model_step();
      int pn;
      if (!rst_n) begin
         m_flags = '0; m_pend = 0; m_held = 0; m_go = 0;
         m_rv = 0; m_rt = 0; m_tgt = '0;
         return;
      end
      pn = m_pend;
      if (flag_pend_inc && !flag_wr_en) pn = (m_pend < PMAX) ? m_pend + 1 : PMAX;
      else if (flag_wr_en && !flag_pend_inc) pn = (m_pend > 0) ? m_pend - 1 : 0;
      m_rv = 0;
      if (m_held && m_go) begin
         if (!flush) begin
            m_rt  = ref_take(m_cond, m_flags);
            m_tgt = m_rt ? m_pc + m_off : m_pc + 4;
            m_rv  = 1;
         end
         m_held = 0;
         m_go   = 0;
      end else if (m_held) begin
         if (flush) m_held = 0;
         else if (pn == 0) m_go = 1;
      end else if (br_valid && !flush) begin
         m_cond = br_cond; m_pc = br_pc; m_off = br_offset;
         m_held = 1;
         m_go   = (pn == 0);
      end
      if (flag_wr_en) m_flags = {alu_n, alu_z, alu_c, alu_v};
      m_pend = pn;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      br_valid = 0; flag_wr_en = 0; flag_pend_inc = 0; flush = 0;
   endtask

   task automatic drive_branch(input bit [3:0] c, input bit [31:0] pc, input bit [31:0] off);
      br_valid = 1; br_cond = c; br_pc = pc; br_offset = off;
   endtask

   task automatic drive_flags(input bit [3:0] f);
      flag_wr_en = 1; {alu_n, alu_z, alu_c, alu_v} = f;
   endtask

   task automatic test_reset();
      rst_n = 0;
      tick(); tick();
      checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", br_ready); end
      checks++; if (flags_q !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h exp 0", flags_q); end
      checks++; if (res_valid !== 1'b0 || res_taken !== 1'b0 || redirect_valid !== 1'b0) begin
         errors++; $display("FAIL reset_res: got v=%b t=%b r=%b exp 0", res_valid, res_taken, redirect_valid); end
      checks++; if (res_target !== '0) begin errors++; $display("FAIL reset_target: got %h exp 0", res_target); end
      rst_n = 1;
   endtask

   task automatic test_basic();
      drive_flags(4'b0100);
      tick();
      checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL basic_flags: got %b exp 0100", flags_q); end
      drive_branch(4'd0, 32'h100, 32'h20);
      tick();
      checks++; if (br_ready !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL basic_eval: got ready=%b valid=%b exp 0 0", br_ready, res_valid); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || redirect_valid !== 1'b1) begin
         errors++; $display("FAIL basic_res: got v=%b t=%b r=%b exp 1 1 1", res_valid, res_taken, redirect_valid); end
      checks++; if (res_target !== 32'h120) begin errors++; $display("FAIL basic_target: got %h exp 120", res_target); end
      checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b exp 1", br_ready); end
      tick();
      checks++; if (res_valid !== 1'b0 || res_target !== 32'h120) begin
         errors++; $display("FAIL basic_hold: got v=%b tgt=%h exp 0 120", res_valid, res_target); end
   endtask

   task automatic test_sweep();
      bit exp_t;
      for (int c = 0; c < 16; c++) begin
         for (int f = 0; f < 16; f++) begin
            drive_flags(4'(f));
            drive_branch(4'(c), 32'h1000, -32'sd8);
            tick(); tick();
            exp_t = ref_take(4'(c), 4'(f));
            checks++; if (res_valid !== 1'b1 || res_taken !== exp_t) begin
               errors++; $display("FAIL sweep_taken c=%0d f=%h: got v=%b t=%b exp 1 %b", c, f, res_valid, res_taken, exp_t); end
            checks++; if (res_target !== (exp_t ? 32'hFF8 : 32'h1004)) begin
               errors++; $display("FAIL sweep_target c=%0d f=%h: got %h exp %h", c, f, res_target, exp_t ? 32'hFF8 : 32'h1004); end
            checks++; if (redirect_valid !== exp_t) begin
               errors++; $display("FAIL sweep_redirect c=%0d f=%h: got %b exp %b", c, f, redirect_valid, exp_t); end
         end
      end
   endtask

   task automatic test_stall();
      flag_pend_inc = 1; tick();
      flag_pend_inc = 1; tick();
      drive_branch(4'd8, 32'h200, 32'h40);
      tick();
      checks++; if (br_ready !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL stall_held: got ready=%b valid=%b exp 0 0", br_ready, res_valid); end
      drive_flags(4'b0000);
      tick();
      checks++; if (res_valid !== 1'b0 || br_ready !== 1'b0) begin
         errors++; $display("FAIL stall_after_w1: got v=%b ready=%b exp 0 0", res_valid, br_ready); end
      tick(); tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_gap: got %b exp 0", res_valid); end
      drive_flags(4'b0010);
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_w2_early: got %b exp 0", res_valid); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_taken !== 1'b1 || res_target !== 32'h240) begin
         errors++; $display("FAIL stall_resolve: got v=%b t=%b tgt=%h exp 1 1 240", res_valid, res_taken, res_target); end
   endtask

   task automatic test_pend_counter();
      flag_pend_inc = 1; tick();
      flag_pend_inc = 1; drive_flags(4'b0000); tick();
      drive_branch(4'd14, 32'h300, 32'h10);
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++; if (res_valid !== 1'b0 || br_ready !== 1'b0) begin
            errors++; $display("FAIL pend_both_wait[%0d]: got v=%b ready=%b exp 0 0", i, res_valid, br_ready); end
         tick();
      end
      drive_flags(4'b0000); tick(); tick();
      checks++; if (res_valid !== 1'b1 || res_target !== 32'h310) begin
         errors++; $display("FAIL pend_both_release: got v=%b tgt=%h exp 1 310", res_valid, res_target); end
      for (int i = 0; i < 4; i++) begin flag_pend_inc = 1; tick(); end
      drive_branch(4'd14, 32'h400, 32'h8);
      tick();
      drive_flags(4'b0000); tick();
      drive_flags(4'b0000); tick();
      checks++; if (br_ready !== 1'b0 || res_valid !== 1'b0) begin
         errors++; $display("FAIL pend_sat_two_wr: got ready=%b v=%b exp 0 0", br_ready, res_valid); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL pend_sat_still: got %b exp 0", res_valid); end
      drive_flags(4'b0000); tick(); tick();
      checks++; if (res_valid !== 1'b1 || res_target !== 32'h408) begin
         errors++; $display("FAIL pend_sat_release: got v=%b tgt=%h exp 1 408", res_valid, res_target); end
   endtask

   task automatic test_flush();
      flag_pend_inc = 1; tick();
      drive_branch(4'd14, 32'h500, 32'h4);
      tick();
      flush = 1; tick();
      checks++; if (br_ready !== 1'b1 || res_valid !== 1'b0) begin
         errors++; $display("FAIL flush_wait: got ready=%b v=%b exp 1 0", br_ready, res_valid); end
      drive_flags(4'b0000); tick();
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_quiet[%0d]: got %b exp 0", i, res_valid); end
      end
      drive_branch(4'd14, 32'h520, 32'h4); flush = 1;
      tick();
      checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready: got %b exp 1", br_ready); end
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_quiet: got %b exp 0", res_valid); end
      drive_branch(4'd14, 32'h540, 32'h4);
      tick();
      flush = 1; tick();
      checks++; if (res_valid !== 1'b0 || br_ready !== 1'b1) begin
         errors++; $display("FAIL flush_eval: got v=%b ready=%b exp 0 1", res_valid, br_ready); end
   endtask

   task automatic test_reset_mid();
      drive_flags(4'b1111);
      drive_branch(4'd14, 32'h600, 32'h0);
      tick(); tick();
      drive_branch(4'd14, 32'h610, 32'h0);
      tick();
      rst_n = 0; flag_pend_inc = 1;
      tick();
      checks++; if (res_valid !== 1'b0 || res_taken !== 1'b0 || redirect_valid !== 1'b0 || res_target !== '0 || flags_q !== 4'h0) begin
         errors++; $display("FAIL reset_mid_out: got v=%b t=%b r=%b tgt=%h f=%h exp all 0", res_valid, res_taken, redirect_valid, res_target, flags_q); end
      checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b exp 1", br_ready); end
      rst_n = 1;
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_nopulse: got %b exp 0", res_valid); end
      drive_branch(4'd14, 32'h620, 32'h4);
      tick(); tick();
      checks++; if (res_valid !== 1'b1 || res_target !== 32'h624) begin
         errors++; $display("FAIL reset_mid_pend_clear: got v=%b tgt=%h exp 1 624", res_valid, res_target); end
   endtask

   task automatic test_wrap();
      drive_branch(4'd14, 32'hFFFF_FFFC, 32'h8);
      tick(); tick();
      checks++; if (res_taken !== 1'b1 || res_target !== 32'h4) begin
         errors++; $display("FAIL wrap_taken: got t=%b tgt=%h exp 1 4", res_taken, res_target); end
      drive_branch(4'd15, 32'hFFFF_FFFC, 32'h8);
      tick(); tick();
      checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_target !== 32'h0 || redirect_valid !== 1'b0) begin
         errors++; $display("FAIL wrap_never: got v=%b t=%b tgt=%h r=%b exp 1 0 0 0", res_valid, res_taken, res_target, redirect_valid); end
   endtask

   task automatic test_back_to_back();
      drive_branch(4'd14, 32'h700, 32'h10);
      tick(); tick();
      checks++; if (res_valid !== 1'b1 || br_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_first: got v=%b ready=%b exp 1 1", res_valid, br_ready); end
      drive_branch(4'd15, 32'h800, 32'h10);
      tick();
      checks++; if (res_valid !== 1'b0 || br_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got v=%b ready=%b exp 0 0", res_valid, br_ready); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_taken !== 1'b0 || res_target !== 32'h804) begin
         errors++; $display("FAIL b2b_second: got v=%b t=%b tgt=%h exp 1 0 804", res_valid, res_taken, res_target); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst_n         = ($urandom_range(99) >= 2);
         br_valid      = $urandom_range(1);
         flag_pend_inc = ($urandom_range(99) < 15);
         flag_wr_en    = ($urandom_range(99) < 25);
         flush         = ($urandom_range(99) < 5);
         {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
         br_cond   = 4'($urandom);
         br_pc     = $urandom;
         br_offset = ($urandom_range(1) != 0) ? $urandom : 32'($urandom_range(64));
         tick();
         checks++; if (br_ready !== !m_held || flags_q !== m_flags || res_valid !== m_rv) begin
            errors++; $display("FAIL rand_ctrl[%0d]: got ready=%b f=%h v=%b exp %b %h %b", i, br_ready, flags_q, res_valid, !m_held, m_flags, m_rv); end
         checks++; if (res_taken !== m_rt || res_target !== m_tgt || redirect_valid !== (m_rv && m_rt)) begin
            errors++; $display("FAIL rand_res[%0d]: got t=%b tgt=%h r=%b exp %b %h %b", i, res_taken, res_target, redirect_valid, m_rt, m_tgt, m_rv && m_rt); end
      end
      rst_n = 1;
   endtask

   initial begin
      rst_n = 0; flag_pend_inc = 0; flag_wr_en = 0; flush = 0; br_valid = 0;
      {alu_n, alu_z, alu_c, alu_v} = 4'h0;
      br_cond = '0; br_pc = '0; br_offset = '0;
      test_reset();
      test_basic();
      test_sweep();
      test_stall();
      test_pend_counter();
      test_flush();
      test_reset_mid();
      test_wrap();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
